// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: geometry, pointer type and Gray/binary helpers.
package fifo_pkg;

    localparam int PTR_WIDTH = 8;
    localparam int DEPTH     = 256;

    // One extra wrap bit distinguishes full from empty when the address bits match.
    typedef logic [PTR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[PTR_WIDTH] = gray[PTR_WIDTH];
        for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/wptr_handler_if.sv
// Write-side bus of the async FIFO: request, synchronised read pointer and write status.
interface wptr_handler_if #(
    parameter int PTR_WIDTH = fifo_pkg::PTR_WIDTH
);
    logic                 w_en;
    logic [PTR_WIDTH:0]   g_rptr_sync;
    logic [PTR_WIDTH:0]   b_wptr;
    logic [PTR_WIDTH:0]   g_wptr;
    logic                 w_accept;
    logic                 full;
    logic                 almost_full;
    logic                 half_full;
    logic [PTR_WIDTH:0]   wr_level;
    logic                 write_error;
    logic [15:0]          err_count;

    modport master (
        output w_en, g_rptr_sync,
        input  b_wptr, g_wptr, w_accept, full, almost_full, half_full,
               wr_level, write_error, err_count
    );

    modport slave (
        input  w_en, g_rptr_sync,
        output b_wptr, g_wptr, w_accept, full, almost_full, half_full,
               wr_level, write_error, err_count
    );
endinterface

// File: rtl/wptr_handler_gray2bin.sv
// Combinational Gray-to-binary converter; shared by the write- and read-side pointer handlers.
module gray2bin #(
    parameter int WIDTH = fifo_pkg::PTR_WIDTH + 1
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // Each binary bit is the parity of all Gray bits at and above it.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/wptr_handler.sv
// Write-domain pointer/status generator: advances binary and Gray write pointers and derives
// full, almost-full, half-full and occupancy from the synchronised Gray read pointer.
module wptr_handler #(
    parameter int DEPTH     = fifo_pkg::DEPTH,
    parameter int PTR_WIDTH = fifo_pkg::PTR_WIDTH,
    parameter int AF_MARGIN = 4
) (
    input  logic           wclk,
    input  logic           wrst,
    wptr_handler_if.slave  bus
);

    typedef logic [PTR_WIDTH:0] wptr_t;

    localparam wptr_t HF_THRESH = wptr_t'(DEPTH / 2);
    localparam wptr_t AF_THRESH = wptr_t'(DEPTH - AF_MARGIN);

    generate
        if (DEPTH != 2 ** PTR_WIDTH) begin : g_depth_check
            $error("wptr_handler: DEPTH must equal 2**PTR_WIDTH");
        end
    endgenerate

    wptr_t         r_b_wptr;
    wptr_t         r_g_wptr;
    logic          r_full;
    logic          r_almost_full;
    logic          r_half_full;
    wptr_t         r_wr_level;
    logic          r_write_error;
    logic [15:0]   r_err_count;

    logic          w_wr_accept;
    logic          w_wr_reject;
    wptr_t         w_b_wptr_next;
    wptr_t         w_g_wptr_next;
    wptr_t         w_rptr_bin;
    wptr_t         w_level_next;
    wptr_t         w_full_match;

    gray2bin #(
        .WIDTH (PTR_WIDTH + 1)
    ) u_rptr_g2b (
        .i_gray (bus.g_rptr_sync),
        .o_bin  (w_rptr_bin)
    );

    // Acceptance depends only on the registered flag, so no read-domain path reaches the memory enable.
    assign w_wr_accept   = bus.w_en && !r_full;
    assign w_wr_reject   = bus.w_en && r_full;
    assign w_b_wptr_next = r_b_wptr + wptr_t'(w_wr_accept);
    assign w_g_wptr_next = w_b_wptr_next ^ (w_b_wptr_next >> 1);
    assign w_level_next  = w_b_wptr_next - w_rptr_bin;

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
    assign w_full_match  = {~bus.g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1],
                             bus.g_rptr_sync[PTR_WIDTH-2:0]};

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_b_wptr      <= '0;
            r_g_wptr      <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_half_full   <= 1'b0;
            r_wr_level    <= '0;
            r_write_error <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_b_wptr      <= w_b_wptr_next;
            r_g_wptr      <= w_g_wptr_next;
            r_full        <= (w_g_wptr_next == w_full_match);
            r_almost_full <= (w_level_next >= AF_THRESH);
            r_half_full   <= (w_level_next >= HF_THRESH);
            r_wr_level    <= w_level_next;
            r_write_error <= w_wr_reject;
            if (w_wr_reject && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign bus.w_accept    = w_wr_accept;
    assign bus.b_wptr      = r_b_wptr;
    assign bus.g_wptr      = r_g_wptr;
    assign bus.full        = r_full;
    assign bus.almost_full = r_almost_full;
    assign bus.half_full   = r_half_full;
    assign bus.wr_level    = r_wr_level;
    assign bus.write_error = r_write_error;
    assign bus.err_count   = r_err_count;

endmodule

// File: tb/tb_wptr_handler.sv
// Randomised scoreboard bench for wptr_handler: an occupancy-arithmetic model predicts every
// post-edge output; a monitor compares each cycle.
module tb_wptr_handler;

    localparam int PW    = 8;
    localparam int DEPTH = 256;
    localparam int MOD   = 2 * DEPTH;

    logic clk;
    logic wrst;

    wptr_handler_if #(.PTR_WIDTH(PW)) bus ();

    wptr_handler #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PW),
        .AF_MARGIN (4)
    ) dut (
        .wclk (clk),
        .wrst (wrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  b;
        logic [8:0]  g;
        logic [8:0]  lvl;
        logic        full;
        logic        af;
        logic        hf;
        logic        werr;
        logic        acc;
        logic [15:0] ec;
    } exp_t;

    exp_t q[$];

    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_txn    = 0;

    // Reference state: total accepted writes and read position, both modulo 2*DEPTH.
    int  m_w  = 0;
    bit  m_full = 1'b0;
    int  m_ec = 0;
    int  rd   = 0;

    function automatic logic [8:0] to_gray(input int v);
        logic [8:0] b;
        b = 9'(v);
        return b ^ (b >> 1);
    endfunction

    function automatic int occ(input int w, input int r);
        return ((w - r) % MOD + MOD) % MOD;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s txn=%0d got=%0h exp=%0h", name, n_txn, got, exp);
    endtask

    task automatic drive(input bit en, input bit rst, input int rb);
        exp_t e;
        int   lvl;
        bit   acc;
        bit   rej;
        @(negedge clk);
        bus.w_en        = en;
        wrst            = rst;
        bus.g_rptr_sync = to_gray(rb);
        if (rst) begin
            m_w = 0; m_full = 1'b0; m_ec = 0;
            e.b = 9'd0; e.g = 9'd0; e.lvl = 9'd0;
            e.full = 1'b0; e.af = 1'b0; e.hf = 1'b0; e.werr = 1'b0; e.ec = 16'd0;
        end else begin
            acc = en && !m_full;
            rej = en && m_full;
            m_w = (m_w + int'(acc)) % MOD;
            lvl = occ(m_w, rb);
            m_full = (lvl == DEPTH);
            if (rej && m_ec < 65535) m_ec++;
            e.b = 9'(m_w); e.g = to_gray(m_w); e.lvl = 9'(lvl);
            e.full = m_full; e.af = (lvl >= DEPTH - 4); e.hf = (lvl >= DEPTH / 2);
            e.werr = rej; e.ec = 16'(m_ec);
        end
        e.acc = en && !e.full;
        q.push_back(e);
    endtask

    // Monitor: every edge that has a pending prediction is checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_txn++;
                chk("b_wptr",      32'(bus.b_wptr),      32'(e.b));
                chk("g_wptr",      32'(bus.g_wptr),      32'(e.g));
                chk("wr_level",    32'(bus.wr_level),    32'(e.lvl));
                chk("full",        32'(bus.full),        32'(e.full));
                chk("almost_full", 32'(bus.almost_full), 32'(e.af));
                chk("half_full",   32'(bus.half_full),   32'(e.hf));
                chk("write_error", 32'(bus.write_error), 32'(e.werr));
                chk("err_count",   32'(bus.err_count),   32'(e.ec));
                chk("w_accept",    32'(bus.w_accept),    32'(e.acc));
                $display("txn %0d: b_wptr=%03h g_wptr=%03h lvl=%0d full=%0b af=%0b hf=%0b werr=%0b ec=%0d",
                         n_txn, bus.b_wptr, bus.g_wptr, bus.wr_level, bus.full,
                         bus.almost_full, bus.half_full, bus.write_error, bus.err_count);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int wp;
        int rp;
        wrst            = 1'b1;
        bus.w_en        = 1'b0;
        bus.g_rptr_sync = '0;

        // Reset held with a pending write request.
        drive(1'b1, 1'b1, 0);
        drive(1'b1, 1'b1, 0);

        // Fill from empty, then overflow attempts.
        rd = 0;
        for (int i = 0; i < 256; i++) drive(1'b1, 1'b0, rd);
        for (int i = 0; i < 3; i++)   drive(1'b1, 1'b0, rd);

        // Release by one read, then refill.
        rd = 1;
        drive(1'b0, 1'b0, rd);
        drive(1'b1, 1'b0, rd);
        drive(1'b1, 1'b0, rd);

        // Random traffic in balanced, write-heavy and read-heavy segments; wraps pointers repeatedly.
        for (int i = 0; i < 4500; i++) begin
            case ((i / 500) % 3)
                0:       begin wp = 50; rp = 50; end
                1:       begin wp = 88; rp = 25; end
                default: begin wp = 25; rp = 88; end
            endcase
            if (occ(m_w, rd) > 0 && $urandom_range(99) < rp) rd = (rd + 1) % MOD;
            drive($urandom_range(99) < wp, 1'b0, rd);
        end

        // Mid-operation reset at level 100 with a write pending.
        rd = 0;
        drive(1'b0, 1'b1, rd);
        for (int i = 0; i < 100; i++) drive(1'b1, 1'b0, rd);
        drive(1'b1, 1'b1, rd);
        drive(1'b1, 1'b0, rd);
        drive(1'b0, 1'b0, rd);

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got=%0d exp=0 pending predictions", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
